// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl
// Frame-scan sequencer for an LED-matrix panel using binary-coded modulation.
// For every row and every bit plane it shifts one row of columns, blanks the
// panel, pulses latch, then lights the panel for BASE_DISPLAY << plane cycles.
//
// Ports:
//   clk        in   single clock, all state updates on posedge
//   rst        in   synchronous active-low reset
//   start      in   begin one frame; level, sampled only while idle
//   busy       out  high from the first shift cycle to the last display cycle
//   col        out  current column (framebuffer read address)
//   row        out  current row (framebuffer address and panel row address)
//   plane      out  current bit plane
//   shift_en   out  one cycle per column: shift strobe and read enable
//   latch      out  one-cycle latch pulse
//   oe_n       out  panel output enable, active low
//   frame_done out  one-cycle pulse in the first idle cycle after a full frame
//
// Handshake: start is a plain level request. It is honoured on the rising
// edge where the sequencer is idle (including the frame_done cycle) and is
// ignored at every other time; there is no ready/ack signal, busy=0 means
// the next sampled start will be taken.
//
// All outputs are registered: each state transition also loads the output
// values for the state being entered, so nothing combinational reaches a pin.
// Read data from the framebuffer arrives one cycle after shift_en; the
// downstream shifter is expected to delay shift_en to match.
module led_scan_ctrl #(
  parameter int COLS         = 64,
  parameter int ROWS         = 16,
  parameter int PLANES       = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int BASE_DISPLAY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic [$clog2(COLS)-1:0]   col,
  output logic [$clog2(ROWS)-1:0]   row,
  output logic [$clog2(PLANES)-1:0] plane,
  output logic                      shift_en,
  output logic                      latch,
  output logic                      oe_n,
  output logic                      frame_done
);

  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int PLANE_W = $clog2(PLANES);

  // Wide enough for the longest display interval, so it never overflows.
  localparam int DLY_MAIN = $clog2(BASE_DISPLAY << (PLANES - 1)) + 1;
  localparam int DLY_BLK  = $clog2(BLANK_CYCLES) + 1;
  localparam int DLY_W    = (DLY_MAIN > DLY_BLK) ? DLY_MAIN : DLY_BLK;

  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(PLANES - 1);
  localparam logic [DLY_W-1:0]   BLANK_INIT = DLY_W'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    BLANK   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_t;

  // state is kept as a named enum register so checkers can bind to it.
  state_t           state;
  logic [DLY_W-1:0] dly;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      plane      <= '0;
      dly        <= '0;
      busy       <= 1'b0;
      shift_en   <= 1'b0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      // frame_done is a single-cycle pulse; only the DISPLAY exit sets it.
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            col      <= '0;
            shift_en <= 1'b1;
            busy     <= 1'b1;
          end
        end

        SHIFT: begin
          if (col == LAST_COL) begin
            state    <= BLANK;
            col      <= '0;
            shift_en <= 1'b0;
            dly      <= BLANK_INIT;
          end else begin
            col <= col + 1'b1;
          end
        end

        // dly counts down to zero; the state lasts dly_init + 1 cycles.
        BLANK: begin
          if (dly == '0) begin
            state <= LATCH;
            latch <= 1'b1;
          end else begin
            dly <= dly - 1'b1;
          end
        end

        LATCH: begin
          state <= DISPLAY;
          latch <= 1'b0;
          oe_n  <= 1'b0;
          dly   <= DLY_W'((BASE_DISPLAY << plane) - 1);
        end

        DISPLAY: begin
          if (dly == '0) begin
            oe_n <= 1'b1;
            if (plane != LAST_PLANE) begin
              state    <= SHIFT;
              plane    <= plane + 1'b1;
              shift_en <= 1'b1;
            end else if (row != LAST_ROW) begin
              state    <= SHIFT;
              plane    <= '0;
              row      <= row + 1'b1;
              shift_en <= 1'b1;
            end else begin
              state      <= IDLE;
              plane      <= '0;
              row        <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end else begin
            dly <= dly - 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          shift_en <= 1'b0;
          latch    <= 1'b0;
          oe_n     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Testbench for led_scan_ctrl.
// The reference model builds the whole expected output trace of a frame from
// nested loops over row / plane / phase and replays it cycle by cycle.
module tb_led_scan_ctrl;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int PLANES = 2;
  localparam int BLANK = 2;
  localparam int BASE  = 3;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(PLANES);
  // {busy, col, row, plane, shift_en, latch, oe_n, frame_done}
  localparam int W = 5 + CW + RW + PW;
  localparam int FRAME_LEN = ROWS * (PLANES * (COLS + BLANK + 1) + BASE * ((1 << PLANES) - 1));
  localparam int FRAME2_LEN = 16 * (8 * (64 + 2 + 1) + 4 * 255);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, shift_en, latch, oe_n, frame_done;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] plane;

  led_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .PLANES(PLANES),
    .BLANK_CYCLES(BLANK), .BASE_DISPLAY(BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .col(col), .row(row),
    .plane(plane), .shift_en(shift_en), .latch(latch), .oe_n(oe_n),
    .frame_done(frame_done)
  );

  // Default-parameter instance for the full-size frame length check.
  logic       rst2 = 1'b0;
  logic       start2 = 1'b0;
  logic       busy2, shift_en2, latch2, oe_n2, frame_done2;
  logic [5:0] col2;
  logic [3:0] row2;
  logic [2:0] plane2;

  led_scan_ctrl dut2 (
    .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .col(col2), .row(row2),
    .plane(plane2), .shift_en(shift_en2), .latch(latch2), .oe_n(oe_n2),
    .frame_done(frame_done2)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  int n_shift = 0;
  int n_latch = 0;
  int n_oe = 0;

  function automatic logic [W-1:0] pack(bit b, int c, int r, int p, bit s, bit l, bit o, bit f);
    return {b, CW'(c), RW'(r), PW'(p), s, l, o, f};
  endfunction

  localparam logic [W-1:0] IDLE_V = {1'b0, {(CW + RW + PW){1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic build_frame();
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int p = 0; p < PLANES; p++) begin
        for (int c = 0; c < COLS; c++) exp_q.push_back(pack(1, c, r, p, 1, 0, 1, 0));
        for (int b = 0; b < BLANK; b++) exp_q.push_back(pack(1, 0, r, p, 0, 0, 1, 0));
        exp_q.push_back(pack(1, 0, r, p, 0, 1, 1, 0));
        for (int d = 0; d < (BASE << p); d++) exp_q.push_back(pack(1, 0, r, p, 0, 0, 0, 0));
      end
    end
    exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 1, 1));
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Applies inputs for one cycle, advances the model, then checks after the edge.
  task automatic step(bit s, bit r);
    logic [W-1:0] nxt;
    start = s;
    rst   = r;
    if (!r) begin
      exp_q.delete();
      nxt = IDLE_V;
    end else begin
      if (!cur_exp[W-1] && s) build_frame();
      nxt = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
    end
    @(posedge clk);
    #1;
    check("outputs", 32'({busy, col, row, plane, shift_en, latch, oe_n, frame_done}), 32'(nxt));
    check("oe_overlap", 32'(!oe_n && (shift_en || latch)), 32'd0);
    if (!r) begin
      n_shift = 0; n_latch = 0; n_oe = 0;
    end else begin
      n_shift += int'(shift_en);
      n_latch += int'(latch);
      n_oe    += int'(!oe_n);
      if (frame_done) begin
        check("cnt_shift", 32'(n_shift), 32'(ROWS * PLANES * COLS));
        check("cnt_latch", 32'(n_latch), 32'(ROWS * PLANES));
        check("cnt_oe_low", 32'(n_oe), 32'(ROWS * BASE * ((1 << PLANES) - 1)));
        n_shift = 0; n_latch = 0; n_oe = 0;
      end
    end
    cur_exp = nxt;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int fd_at;
    int n;
    int busy_cnt;
    cur_exp = IDLE_V;

    // 1. reset with start held high
    repeat (3) step(1, 0);

    // 2. single frame: start at cycle 0
    step(1, 1);
    fd_at = -1;
    for (int i = 1; i <= 52; i++) begin
      step(0, 1);
      if (frame_done && fd_at < 0) fd_at = i + 1;
    end
    check("single_fd_cycle", 32'(fd_at), 32'(FRAME_LEN + 1));

    // 4a. start pulses at 10 and 30 are ignored
    step(1, 1);
    for (int i = 1; i <= 52; i++) step(i == 10 || i == 30, 1);

    // 4b. start held high: back-to-back frames
    fd_at = -1;
    for (int i = 0; i < 100; i++) begin
      step(1, 1);
      if (frame_done && fd_at < 0) fd_at = i + 1;
      if (i + 1 == FRAME_LEN + 2)
        check("b2b_shift_col0", 32'({shift_en, busy, col}), 32'({1'b1, 1'b1, CW'(0)}));
    end
    check("b2b_fd_cycle", 32'(fd_at), 32'(FRAME_LEN + 1));
    repeat (60) step(0, 1);

    // 5. reset during plane-1 display, then a full frame
    step(1, 1);
    for (int i = 1; i < 20; i++) step(0, 1);
    step(0, 0);
    check("midreset_no_fd", 32'({frame_done, busy}), 32'd0);
    repeat (3) step(0, 1);
    step(1, 1);
    fd_at = -1;
    for (int i = 1; i <= 50; i++) begin
      step(0, 1);
      if (frame_done && fd_at < 0) fd_at = i + 1;
    end
    check("after_reset_fd_cycle", 32'(fd_at), 32'(FRAME_LEN + 1));

    // random start / reset traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 90) != 0);
    repeat (3) step(0, 0);

    // 6. default parameters: full frame length
    start = 1'b0;
    rst   = 1'b1;
    rst2  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst2   = 1'b1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (!frame_done2 && n < FRAME2_LEN + 1000) begin
      busy_cnt += int'(busy2);
      @(posedge clk);
      #1;
      n++;
    end
    check("default_fd_cycle", 32'(n), 32'(FRAME2_LEN + 1));
    check("default_busy_len", 32'(busy_cnt), 32'(FRAME2_LEN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Frame-scan sequencer for the LED-matrix output path. It drives the column, row and bit-plane counters in lock-step and produces the per-column shift strobe, the latch pulse and the active-low output-enable. Display time per plane is binary-weighted (BCM). It sits between the framebuffer read port, which consumes col/row/plane as a read address, and the panel shift/latch pins.

## Interface
Parameters:
- COLS, 64: columns shifted per row.
- ROWS, 16: scanned row addresses.
- PLANES, 8: bit planes per colour.
- BLANK_CYCLES, 2: cycles with oe_n high before the latch; minimum 1.
- BASE_DISPLAY, 4: display cycles for plane 0; plane p displays BASE_DISPLAY << p cycles.

Ports (widths derived from parameters):
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-low reset: rst = 0 at a rising edge resets the block.
- start  in  1  begin one frame; sampled only in IDLE.
- busy  out  1  high from the first SHIFT cycle to the last DISPLAY cycle.
- col  out  clog2(COLS)  current column; framebuffer read address.
- row  out  clog2(ROWS)  current row; also the panel row address.
- plane  out  clog2(PLANES)  current bit plane.
- shift_en  out  1  high for exactly one cycle per column: the shift strobe and read enable.
- latch  out  1  one-cycle latch pulse.
- oe_n  out  1  panel output enable, active low.
- frame_done  out  1  one-cycle pulse on return to IDLE after a complete frame.

## Operation
States are IDLE, SHIFT, BLANK, LATCH and DISPLAY.

Reset and IDLE:
- Reset forces IDLE and col = row = plane = 0, shift_en = latch = busy = frame_done = 0, oe_n = 1, with all internal counters cleared.
- Reset has priority over every other input, including mid-frame; the frame is abandoned and frame_done is not pulsed.
- IDLE: outputs hold their reset values except frame_done. start = 1 moves the FSM to SHIFT. start is ignored in every other state.

Per-state behaviour:
- SHIFT: shift_en = 1, oe_n = 1. col increments by 1 each cycle from 0. In the cycle where col = COLS-1, the next state is BLANK and col wraps to 0.
- BLANK: oe_n = 1 and shift_en = 0 for BLANK_CYCLES cycles, then LATCH.
- LATCH: latch = 1 and oe_n = 1 for one cycle, then DISPLAY.
- DISPLAY: oe_n = 0 for BASE_DISPLAY << plane cycles. On exit:
  - plane < PLANES-1: plane += 1, next state SHIFT.
  - plane = PLANES-1 and row < ROWS-1: plane = 0, row += 1, next state SHIFT.
  - plane = PLANES-1 and row = ROWS-1: plane = row = 0, next state IDLE, frame_done = 1 in that first IDLE cycle.

Counters:
- row and plane stay constant from SHIFT through DISPLAY of the same plane.
- Internal delay counter width is clog2(BASE_DISPLAY << (PLANES-1)) + 1 bits, so it cannot overflow.
- All counters wrap only as stated above; no other wrap occurs.

Simultaneous events:
- start asserted in the same cycle as frame_done (first IDLE cycle) is accepted. The next frame's first SHIFT cycle follows immediately.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- The cycle after start is sampled in IDLE is the first SHIFT cycle: shift_en = 1, col = 0, busy = 1.
- Per-plane period is COLS + BLANK_CYCLES + 1 + (BASE_DISPLAY << p) cycles.
- Frame length is ROWS × (PLANES × (COLS + BLANK_CYCLES + 1) + BASE_DISPLAY × (2^PLANES − 1)) cycles. frame_done follows the last frame cycle with no gap.
- oe_n is never low while shift_en or latch is high.
- latch is never high while oe_n is low.
- The framebuffer read has one-cycle latency. The downstream shifter aligns read data to the shift_en delayed by one cycle; this block does not compensate.

## Test plan
All scenarios use COLS=4, ROWS=2, PLANES=2, BLANK_CYCLES=2, BASE_DISPLAY=3. Row period = 10 + 13 = 23 cycles; frame = 46 cycles.

1. Reset values: rst = 0 for 3 cycles with start = 1 → busy = 0, oe_n = 1, and all other outputs 0 throughout.
2. Single frame: start at cycle 0 → busy high for cycles 1–46, frame_done only at cycle 47, then IDLE.
   - shift_en high for cycles 1–4 with col = 0,1,2,3, then BLANK for cycles 5–6.
   - latch at cycle 7; oe_n = 0 for cycles 8–10.
   - Plane 1 shifts in cycles 11–14 and oe_n = 0 for cycles 18–23.
   - row = 1 from cycle 24.
3. Counting: over one frame, count 16 shift_en pulses, 4 latch pulses and 18 oe_n-low cycles. Check the assertion that oe_n is never low while shift_en or latch is high.
4. Ignored and back-to-back start:
   - start pulsed at cycles 0, 10 and 30 → the pulses at 10 and 30 have no effect.
   - start held high → frame_done at cycle 47 and shift_en with col = 0 at cycle 48.
5. Reset mid-frame: rst = 0 at cycle 20 (DISPLAY, plane 1) → next cycle is IDLE with reset values and no frame_done. A new start then gives the full 46-cycle frame.
6. Parameter sweep: defaults (COLS=64, ROWS=16, PLANES=8) → frame_done after 16 × (8 × 67 + 4 × 255) = 24896 cycles.
